// File: rtl/nebula_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nebula_irq_pkg
// Description : Shared definitions for the Nebula interrupt controller and
//               its per-hart claim endpoint: claim-FSM state encoding, the
//               interrupt-flag bit position in a cause word, and the helper
//               that sizes the source-ID field.
// Revision    : 1.0 - initial release
// ============================================================================
package nebula_irq_pkg;

    // Default cause width; the interrupt flag lives in the top bit.
    localparam int IRQ_XLEN          = 64;
    localparam int IRQ_CAUSE_INT_BIT = IRQ_XLEN - 1;

    // Claim endpoint states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CLAIM   = 3'd2,
        ST_SERVICE = 3'd3,
        ST_REARM   = 3'd4
    } irq_claim_state_e;

    // Width of the source-ID field for a controller with num_sources
    // sources. Never returns 0 so single-source builds still get a field.
    function automatic int irq_id_width(input int num_sources);
        if (num_sources <= 2) begin
            return 1;
        end
        return $clog2(num_sources);
    endfunction

endpackage : nebula_irq_pkg
`default_nettype wire

// File: rtl/nebula_hart_irq_claim.sv
`default_nettype none
// ============================================================================
// Module      : nebula_hart_irq_claim
// Description : Hart-side endpoint of the Nebula interrupt controller.
//               Qualifies the controller's pending level with the hart's
//               global/external enables, raises a trap request, issues a
//               one-cycle claim once the pipeline takes the trap, tracks the
//               in-service interrupt until software completion, and holds
//               off re-arming so the level source has time to drop.
//
// Ports       : clk, rst          - clock, synchronous active-high reset
//               irq_pending_i     - controller pending level
//               irq_cause_i       - controller cause (MSB = interrupt flag)
//               global_ie_i       - mstatus.MIE
//               ext_ie_i          - mie.MEIE
//               trap_req_o        - trap request to pipeline
//               trap_cause_o      - cause with trap_req_o (0 otherwise)
//               trap_ack_i        - pipeline took the trap
//               irq_ack_o         - one-cycle claim strobe to controller
//               irq_id_o          - claimed cause (0 when strobe low)
//               complete_i        - software completion strobe
//               complete_id_i     - ID being completed
//               in_service_o      - interrupt claimed, not yet completed
//               err_o             - pulse on an illegal completion
//               claim_count_o     - saturating count of claims issued
//
// Revision    : 1.0 - initial release
// ============================================================================
module nebula_hart_irq_claim
    import nebula_irq_pkg::*;
#(
    parameter int XLEN         = IRQ_XLEN,
    parameter int NUM_SOURCES  = 64,
    parameter int REARM_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_pending_i,
    input  logic [XLEN-1:0] irq_cause_i,
    input  logic            global_ie_i,
    input  logic            ext_ie_i,
    output logic            trap_req_o,
    output logic [XLEN-1:0] trap_cause_o,
    input  logic            trap_ack_i,
    output logic            irq_ack_o,
    output logic [XLEN-1:0] irq_id_o,
    input  logic            complete_i,
    input  logic [XLEN-1:0] complete_id_i,
    output logic            in_service_o,
    output logic            err_o,
    output logic [31:0]     claim_count_o
);

    localparam int ID_W  = irq_id_width(NUM_SOURCES);
    localparam int CNT_W = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;

    localparam logic [CNT_W-1:0] C_REARM_LOAD = CNT_W'(REARM_CYCLES - 1);
    localparam logic [31:0]      C_COUNT_MAX  = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    irq_claim_state_e  r_state;
    logic [XLEN-1:0]   r_cause;
    logic [CNT_W-1:0]  r_rearm_cnt;
    logic [31:0]       r_claim_count;
    logic              r_trap_req;
    logic [XLEN-1:0]   r_trap_cause;
    logic              r_irq_ack;
    logic [XLEN-1:0]   r_irq_id;
    logic              r_in_service;
    logic              r_err;

    irq_claim_state_e  w_state_next;
    logic [XLEN-1:0]   w_cause_next;
    logic [CNT_W-1:0]  w_rearm_cnt_next;
    logic [31:0]       w_claim_count_next;
    logic              w_err_next;
    logic              w_qualified;
    logic              w_id_match;

    // Only the ID field of a completion is compared; the upper bits
    // (interrupt flag and reserved) are deliberately ignored.
    logic              w_unused_complete_id;

    assign w_qualified = irq_pending_i & global_ie_i & ext_ie_i;
    assign w_id_match  = (complete_id_i[ID_W-1:0] == r_cause[ID_W-1:0]);

    assign w_unused_complete_id = ^complete_id_i[XLEN-1:ID_W];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cause_next     = r_cause;
        w_rearm_cnt_next = r_rearm_cnt;
        w_err_next       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_qualified) begin
                    w_state_next = ST_REQ;
                    w_cause_next = irq_cause_i;
                end
            end

            ST_REQ: begin
                // An ack that lands together with a withdrawal still wins:
                // the pipeline has already vectored to the handler.
                if (trap_ack_i) begin
                    w_state_next = ST_CLAIM;
                end else if (!w_qualified) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_CLAIM: begin
                w_state_next = ST_SERVICE;
            end

            ST_SERVICE: begin
                if (complete_i) begin
                    if (w_id_match) begin
                        w_state_next     = ST_REARM;
                        w_rearm_cnt_next = C_REARM_LOAD;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end

            ST_REARM: begin
                if (r_rearm_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_rearm_cnt_next = r_rearm_cnt - 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A completion outside SERVICE has nothing to complete.
        if (complete_i && (r_state != ST_SERVICE)) begin
            w_err_next = 1'b1;
        end
    end

    // Count moves together with the claim strobe so the new value is
    // visible in the same cycle the controller sees irq_ack_o.
    always_comb begin
        w_claim_count_next = r_claim_count;
        if ((w_state_next == ST_CLAIM) && (r_claim_count != C_COUNT_MAX)) begin
            w_claim_count_next = r_claim_count + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers; outputs are decoded from the next state so each strobe
    // appears in the first cycle of the state it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cause       <= '0;
            r_rearm_cnt   <= '0;
            r_claim_count <= '0;
            r_trap_req    <= 1'b0;
            r_trap_cause  <= '0;
            r_irq_ack     <= 1'b0;
            r_irq_id      <= '0;
            r_in_service  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cause       <= w_cause_next;
            r_rearm_cnt   <= w_rearm_cnt_next;
            r_claim_count <= w_claim_count_next;
            r_trap_req    <= (w_state_next == ST_REQ);
            r_trap_cause  <= (w_state_next == ST_REQ) ? w_cause_next : '0;
            r_irq_ack     <= (w_state_next == ST_CLAIM);
            r_irq_id      <= (w_state_next == ST_CLAIM) ? w_cause_next : '0;
            r_in_service  <= (w_state_next == ST_SERVICE);
            r_err         <= w_err_next;
        end
    end

    assign trap_req_o    = r_trap_req;
    assign trap_cause_o  = r_trap_cause;
    assign irq_ack_o     = r_irq_ack;
    assign irq_id_o      = r_irq_id;
    assign in_service_o  = r_in_service;
    assign err_o         = r_err;
    assign claim_count_o = r_claim_count;

endmodule : nebula_hart_irq_claim
`default_nettype wire

// File: tb/tb_nebula_hart_irq_claim.sv
`default_nettype none
// ============================================================================
// Module      : tb_nebula_hart_irq_claim
// Description : Self-checking bench for nebula_hart_irq_claim. Directed
//               stimulus pushes expected claims / error pulses into queues;
//               a monitor on the falling edge pops and compares whenever the
//               DUT strobes irq_ack_o or err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nebula_hart_irq_claim;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            irq_pending_i;
    logic [XLEN-1:0] irq_cause_i;
    logic            global_ie_i;
    logic            ext_ie_i;
    logic            trap_req_o;
    logic [XLEN-1:0] trap_cause_o;
    logic            trap_ack_i;
    logic            irq_ack_o;
    logic [XLEN-1:0] irq_id_o;
    logic            complete_i;
    logic [XLEN-1:0] complete_id_i;
    logic            in_service_o;
    logic            err_o;
    logic [31:0]     claim_count_o;

    nebula_hart_irq_claim #(
        .XLEN         (XLEN),
        .NUM_SOURCES  (64),
        .REARM_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_pending_i (irq_pending_i),
        .irq_cause_i   (irq_cause_i),
        .global_ie_i   (global_ie_i),
        .ext_ie_i      (ext_ie_i),
        .trap_req_o    (trap_req_o),
        .trap_cause_o  (trap_cause_o),
        .trap_ack_i    (trap_ack_i),
        .irq_ack_o     (irq_ack_o),
        .irq_id_o      (irq_id_o),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .in_service_o  (in_service_o),
        .err_o         (err_o),
        .claim_count_o (claim_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] q_claim[$];
    int              q_err[$];

    localparam logic [XLEN-1:0] C_CAUSE5 = 64'h8000_0000_0000_0005;
    localparam logic [XLEN-1:0] C_CAUSE7 = 64'h8000_0000_0000_0007;
    localparam logic [XLEN-1:0] C_CAUSE9 = 64'h8000_0000_0000_0009;
    localparam logic [XLEN-1:0] C_CAUSEA = 64'h8000_0000_0000_000A;
    localparam logic [XLEN-1:0] C_CAUSEB = 64'h8000_0000_0000_000B;
    localparam logic [XLEN-1:0] C_CAUSEC = 64'h8000_0000_0000_000C;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: claim and error strobes against the scoreboard queues,
    // plus the "zero when strobe low" rule on the data outputs.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (irq_ack_o) begin
            if (q_claim.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got id 0x%0h expected no ack", irq_id_o);
            end else begin
                check("claim_id", irq_id_o, q_claim.pop_front());
            end
        end else begin
            check("irq_id_idle_zero", irq_id_o, '0);
        end

        if (!trap_req_o) begin
            check("trap_cause_idle_zero", trap_cause_o, '0);
        end

        if (err_o) begin
            if (q_err.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_err: got err_o=1 expected 0");
            end else begin
                void'(q_err.pop_front());
            end
        end
    end

    // Claim with no hazards, checking the count once in SERVICE, then
    // complete it and let the hold-off expire with pending low.
    task automatic run_claim(input logic [XLEN-1:0] cause,
                             input logic [31:0] exp_count);
        irq_pending_i = 1'b1;
        irq_cause_i   = cause;
        tick();
        check("sat_trap_req", {63'd0, trap_req_o}, 64'd1);
        trap_ack_i    = 1'b1;
        irq_pending_i = 1'b0;
        q_claim.push_back(cause);
        tick();
        trap_ack_i = 1'b0;
        tick();
        check("sat_count", {32'd0, claim_count_o}, {32'd0, exp_count});
        complete_i    = 1'b1;
        complete_id_i = cause;
        tick();
        complete_i = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int  n_edges;
        bit  found;

        rst           = 1'b1;
        irq_pending_i = 1'b0;
        irq_cause_i   = '0;
        global_ie_i   = 1'b0;
        ext_ie_i      = 1'b0;
        trap_ack_i    = 1'b0;
        complete_i    = 1'b0;
        complete_id_i = '0;
        tick();
        tick();

        // Reset state
        check("rst_trap_req",   {63'd0, trap_req_o},   64'd0);
        check("rst_irq_ack",    {63'd0, irq_ack_o},    64'd0);
        check("rst_in_service", {63'd0, in_service_o}, 64'd0);
        check("rst_err",        {63'd0, err_o},        64'd0);
        check("rst_count",      {32'd0, claim_count_o}, 64'd0);
        rst = 1'b0;

        // Basic claim of cause 5
        global_ie_i   = 1'b1;
        ext_ie_i      = 1'b1;
        irq_pending_i = 1'b1;
        irq_cause_i   = C_CAUSE5;
        tick();
        check("req_trap_req",   {63'd0, trap_req_o}, 64'd1);
        check("req_trap_cause", trap_cause_o, C_CAUSE5);
        trap_ack_i = 1'b1;
        q_claim.push_back(C_CAUSE5);
        tick();
        trap_ack_i = 1'b0;
        check("claim_ack",      {63'd0, irq_ack_o},  64'd1);
        check("claim_trap_req", {63'd0, trap_req_o}, 64'd0);
        tick();
        check("svc_ack_single", {63'd0, irq_ack_o},    64'd0);
        check("svc_in_service", {63'd0, in_service_o}, 64'd1);
        check("svc_count",      {32'd0, claim_count_o}, 64'd1);
        check("svc_no_nest",    {63'd0, trap_req_o},   64'd0);

        // Mismatched completion: ID 3 against in-service ID 5
        complete_i    = 1'b1;
        complete_id_i = 64'd3;
        q_err.push_back(1);
        tick();
        complete_i = 1'b0;
        check("mismatch_err",     {63'd0, err_o},        64'd1);
        check("mismatch_service", {63'd0, in_service_o}, 64'd1);
        tick();
        check("mismatch_err_pulse", {63'd0, err_o},      64'd0);

        // Matching completion; pending held high -> new request after hold-off
        complete_i    = 1'b1;
        complete_id_i = 64'd5;
        tick();
        complete_i = 1'b0;
        check("complete_service_low", {63'd0, in_service_o}, 64'd0);
        check("complete_err",         {63'd0, err_o},        64'd0);
        n_edges = 0;
        found   = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            tick();
            if (trap_req_o) begin
                n_edges = i;
                found   = 1'b1;
            end
        end
        // Request visible in cycle C+4, i.e. after the third edge past C.
        check("rearm_edges", 64'(n_edges), 64'd3);

        // Withdraw by dropping the global enable while in REQ
        global_ie_i = 1'b0;
        tick();
        check("withdraw_trap_req", {63'd0, trap_req_o}, 64'd0);

        // Completion while IDLE
        complete_i    = 1'b1;
        complete_id_i = 64'd5;
        q_err.push_back(1);
        tick();
        complete_i = 1'b0;
        check("idle_complete_err",   {63'd0, err_o},        64'd1);
        check("idle_complete_state", {63'd0, in_service_o}, 64'd0);
        tick();

        // Ack and pending drop on the same edge: claim still issued
        global_ie_i   = 1'b1;
        irq_pending_i = 1'b1;
        irq_cause_i   = C_CAUSE7;
        tick();
        check("simul_trap_req", {63'd0, trap_req_o}, 64'd1);
        trap_ack_i    = 1'b1;
        irq_pending_i = 1'b0;
        q_claim.push_back(C_CAUSE7);
        tick();
        trap_ack_i = 1'b0;
        check("simul_ack", {63'd0, irq_ack_o}, 64'd1);
        tick();
        check("simul_service", {63'd0, in_service_o}, 64'd1);
        check("simul_count",   {32'd0, claim_count_o}, 64'd2);
        complete_i    = 1'b1;
        complete_id_i = 64'd7;
        tick();
        complete_i = 1'b0;
        tick();
        tick();
        tick();

        // Reset asserted during the CLAIM cycle
        irq_pending_i = 1'b1;
        irq_cause_i   = C_CAUSE9;
        tick();
        trap_ack_i = 1'b1;
        q_claim.push_back(C_CAUSE9);
        tick();
        trap_ack_i    = 1'b0;
        check("rstclaim_ack", {63'd0, irq_ack_o}, 64'd1);
        rst           = 1'b1;
        irq_pending_i = 1'b0;
        tick();
        check("rstclaim_ack_low",  {63'd0, irq_ack_o},    64'd0);
        check("rstclaim_trap_req", {63'd0, trap_req_o},   64'd0);
        check("rstclaim_service",  {63'd0, in_service_o}, 64'd0);
        check("rstclaim_count",    {32'd0, claim_count_o}, 64'd0);
        rst = 1'b0;
        tick();
        check("rstclaim_no_ack",   {63'd0, irq_ack_o},    64'd0);
        check("rstclaim_no_svc",   {63'd0, in_service_o}, 64'd0);

        // Drop the enable before any ack: no claim, count stays 0
        irq_pending_i = 1'b1;
        irq_cause_i   = C_CAUSEA;
        tick();
        check("ie_drop_req", {63'd0, trap_req_o}, 64'd1);
        global_ie_i = 1'b0;
        tick();
        check("ie_drop_req_low", {63'd0, trap_req_o},    64'd0);
        check("ie_drop_count",   {32'd0, claim_count_o}, 64'd0);
        irq_pending_i = 1'b0;
        global_ie_i   = 1'b1;

        // Ack outside REQ is ignored
        trap_ack_i = 1'b1;
        tick();
        trap_ack_i = 1'b0;
        tick();
        check("stray_ack_ignored", {63'd0, irq_ack_o},    64'd0);
        check("stray_ack_no_svc",  {63'd0, in_service_o}, 64'd0);

        // Saturation: preload one below the maximum, then claim twice
        force dut.r_claim_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_claim_count;
        #1;
        check("sat_preload", {32'd0, claim_count_o}, 64'h0000_0000_FFFF_FFFE);
        run_claim(C_CAUSEB, 32'hFFFF_FFFF);
        run_claim(C_CAUSEC, 32'hFFFF_FFFF);

        tick();
        tick();
        check("claims_drained", 64'(q_claim.size()), 64'd0);
        check("errs_drained",   64'(q_err.size()),   64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nebula_hart_irq_claim
`default_nettype wire

// File: doc/nebula_hart_irq_claim.md
# nebula_hart_irq_claim

Hart-side endpoint of the Nebula interrupt controller's core interface; one instance per hart. Samples the controller's `irq_pending`/`irq_cause` level outputs, gates them with the hart's global and external interrupt enables, and raises a trap request to the pipeline. After the core accepts the trap, it returns a one-cycle `irq_ack`/`irq_id` claim to the controller, tracks the in-service interrupt until software completion, then holds off re-arming so the level source can drop.

## Interface
- `XLEN`, 64: cause/ID width.
- `NUM_SOURCES`, 64: controller source count; the ID field is `$clog2(NUM_SOURCES)` bits.
- `REARM_CYCLES`, 2: hold-off cycles after completion, minimum 1.
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_pending_i`  in  1  controller pending level for this hart.
- `irq_cause_i`  in  XLEN  controller cause: bit XLEN-1 = interrupt flag, low bits = source ID.
- `global_ie_i`  in  1  mstatus.MIE.
- `ext_ie_i`  in  1  mie.MEIE.
- `trap_req_o`  out  1  trap request to the pipeline.
- `trap_cause_o`  out  XLEN  cause accompanying `trap_req_o`.
- `trap_ack_i`  in  1  pipeline has taken the trap.
- `irq_ack_o`  out  1  claim strobe to the controller.
- `irq_id_o`  out  XLEN  claimed cause, full width.
- `complete_i`  in  1  software completion strobe.
- `complete_id_i`  in  XLEN  ID being completed.
- `in_service_o`  out  1  an interrupt is claimed and not yet completed.
- `err_o`  out  1  one-cycle pulse on an illegal completion.
- `claim_count_o`  out  32  saturating count of claims issued.

## Operation
- States: IDLE, REQ, CLAIM, SERVICE, REARM.
- **IDLE:**
  - If `irq_pending_i & global_ie_i & ext_ie_i`, latch `irq_cause_i` into `cause_q` and go to REQ.
- **REQ:**
  - `trap_req_o`=1 and `trap_cause_o`=`cause_q`, frozen while in REQ.
  - `trap_ack_i` → CLAIM.
  - Otherwise, if pending or either enable is low → IDLE (withdraw, no claim issued).
  - `trap_ack_i` takes precedence over a simultaneous withdrawal.
- **CLAIM:**
  - `irq_ack_o`=1 and `irq_id_o`=`cause_q` for exactly one cycle.
  - `claim_count_o` increments and saturates at 0xFFFF_FFFF.
  - Unconditional → SERVICE.
- **SERVICE:**
  - `in_service_o`=1.
  - `complete_i` with `complete_id_i[ID]==cause_q[ID]` (ID = low `$clog2(NUM_SOURCES)` bits) → REARM and load the counter with `REARM_CYCLES-1`.
  - A mismatched ID pulses `err_o` and stays in SERVICE.
  - New pending interrupts are ignored; no nesting.
- **REARM:**
  - Counter decrements each cycle; at 0 → IDLE.
  - Pending is not sampled in REARM.
- `complete_i` in any state other than SERVICE pulses `err_o` and is otherwise ignored.
- `irq_id_o` and `trap_cause_o` drive 0 whenever their strobe is low.

## Timing
- Reset: state IDLE; `trap_req_o`, `irq_ack_o`, `in_service_o`, `err_o` = 0; `trap_cause_o`, `irq_id_o`, `cause_q` = 0; `claim_count_o` = 0; REARM counter = 0.
- All outputs are registered.
- Qualified pending at edge N → `trap_req_o` high from N+1.
- `trap_ack_i` at edge M (while `trap_req_o` is high) → `irq_ack_o` high for cycle M+1 only → `in_service_o` high from M+2.
- Matching `complete_i` at edge C → `in_service_o` low from C+1.
- Earliest new `trap_req_o` is at C+`REARM_CYCLES`+2.
- `err_o` asserts the cycle after the offending `complete_i`.
- `trap_ack_i` outside REQ is ignored.
- Reset asserted in any state, including mid-CLAIM, returns to IDLE next edge with reset values; no ack is issued after reset.

## Structure
- Shared package `nebula_irq_pkg`:
  - state enum `irq_claim_state_e`.
  - `IRQ_CAUSE_INT_BIT = XLEN-1` constant.
  - ID-width helper function, also used by the controller.
- Single flat module; no sub-module (the counters are trivial).

## Test plan
- Enables=1, pending=1, cause=0x8000_0000_0000_0005; `trap_ack_i` one cycle after `trap_req_o` → `irq_ack_o` one cycle with `irq_id_o`=0x8000_0000_0000_0005; `claim_count_o`=1; `in_service_o`=1.
- In REQ, drop `global_ie_i` before any ack → `trap_req_o` low next cycle; `irq_ack_o` never asserts; `claim_count_o`=0.
- In REQ, `trap_ack_i` and pending drop on the same cycle → claim still issued.
- In SERVICE, `complete_id_i`=3 while cause ID=5 → `err_o` one-cycle pulse, still in service. Then ID=5 → `in_service_o` low; with `REARM_CYCLES`=2 and pending held high, the next `trap_req_o` comes exactly 4 cycles after the completion edge.
- `complete_i` in IDLE → `err_o` pulse, no state change.
- Assert `rst` in the CLAIM cycle → all outputs 0 next cycle, state IDLE, `claim_count_o`=0.
- Preload `claim_count_o`=0xFFFF_FFFE, run two claims → count holds at 0xFFFF_FFFF.
